// File: rtl/ctrl_rst.sv
// rtl/ctrl_rst.sv - reset sequencer: lock wait, system hold, CPU delay, run (optional CTRL_RST_DEBOUNCE_EN)
module ctrl_rst #(
  parameter int HOLD_CYCLES = 1024,
  parameter int CPU_DELAY   = 256,
  parameter int DB_CYCLES   = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  input  logic       sw_rst_req,
  output logic       sys_rst,
  output logic       cpu_rst,
  output logic       rst_done,
  output logic [1:0] state
);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_HOLD      = 2'd1;
  localparam logic [1:0] S_CPU       = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] CPU_LAST  = 16'(CPU_DELAY - 1);

  logic        lock_m;
  logic        lock_s;
  logic        btn_m;
  logic        btn_s;
  logic        btn_p;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  state_nxt;

  // Two-flop synchronizers; lock idles unlocked, button idles released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b1;
      btn_s  <= 1'b1;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      btn_m  <= btn_rst_n;
      btn_s  <= btn_m;
    end
  end

`ifdef CTRL_RST_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES);

  logic [DBW-1:0] db_cnt;

  // Count consecutive low samples of the button, saturating once the press is recognized
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (btn_s) begin
      db_cnt <= '0;
    end else if (db_cnt != DB_MAX) begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press drops out on the very first released sample, not a cycle later
  assign btn_p = ~btn_s && (db_cnt == DB_MAX);
`else
  assign btn_p = ~btn_s;
`endif

  // Next-state selection; priority is lock loss, button, software request, counter expiry
  always_comb begin
    state_nxt = state;
    if (!lock_s) begin
      state_nxt = S_WAIT_LOCK;
    end else if (state == S_WAIT_LOCK) begin
      state_nxt = S_HOLD;
    end else if (btn_p) begin
      state_nxt = S_HOLD;
    end else if (state == S_RUN && sw_rst_req) begin
      state_nxt = S_CPU;
    end else if (state == S_HOLD && cnt == HOLD_LAST) begin
      state_nxt = S_CPU;
    end else if (state == S_CPU && cnt == CPU_LAST) begin
      state_nxt = S_RUN;
    end
  end

  // Counter restarts on any state entry and stays pinned at zero while the button is held
  always_comb begin
    cnt_nxt = cnt + 16'd1;
    if (state_nxt != state || btn_p || state == S_WAIT_LOCK || state == S_RUN) begin
      cnt_nxt = '0;
    end
  end

  // State, counter and registered reset outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT_LOCK;
      cnt      <= '0;
      sys_rst  <= 1'b1;
      cpu_rst  <= 1'b1;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sys_rst  <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_HOLD);
      cpu_rst  <= (state_nxt != S_RUN);
      rst_done <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_ctrl_rst.sv
// tb/tb_ctrl_rst.sv - directed table plus randomized model comparison for ctrl_rst
module tb_ctrl_rst;

  localparam int H  = 16;
  localparam int C  = 8;
  localparam int DB = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       btn_rst_n = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       sys_rst;
  logic       cpu_rst;
  logic       rst_done;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  ctrl_rst #(
    .HOLD_CYCLES(H),
    .CPU_DELAY  (C),
    .DB_CYCLES  (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .btn_rst_n (btn_rst_n),
    .sw_rst_req(sw_rst_req),
    .sys_rst   (sys_rst),
    .cpu_rst   (cpu_rst),
    .rst_done  (rst_done),
    .state     (state)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       pll;
    logic       btn;
    logic       sw;
    int         n;
    logic [1:0] st;
    logic       sys;
    logic       cpu;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic pll, input logic btn, input logic sw, input int n,
                              input logic [1:0] st, input logic sys, input logic cpu, input logic done);
    vec_t v;
    v.pll = pll; v.btn = btn; v.sw = sw; v.n = n;
    v.st = st; v.sys = sys; v.cpu = cpu; v.done = done;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s got {state,sys,cpu,done}=%b required=%b", name, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {state, sys_rst, cpu_rst, rst_done};
  endfunction

  // Reference model: sync pipelines as sample history, states as named phases with a countdown
  int m_ls1, m_ls2, m_bs1, m_bs2, m_low, m_st, m_left;

  function automatic void m_reset();
    m_ls1 = 0; m_ls2 = 0; m_bs1 = 1; m_bs2 = 1; m_low = 0; m_st = 0; m_left = 0;
  endfunction

  function automatic void m_step(input logic pll, input logic btn, input logic sw);
    bit lk, bp;
    lk = (m_ls2 != 0);
`ifdef CTRL_RST_DEBOUNCE_EN
    bp = (m_bs2 == 0) && (m_low >= DB);
    m_low = (m_bs2 != 0) ? 0 : m_low + 1;
`else
    bp = (m_bs2 == 0);
`endif
    if (!lk) begin
      m_st = 0;
    end else if (m_st == 0 || bp) begin
      m_st = 1; m_left = H;
    end else if (m_st == 3 && sw) begin
      m_st = 2; m_left = C;
    end else if (m_st == 1 || m_st == 2) begin
      if (m_left == 1) begin
        if (m_st == 1) begin m_st = 2; m_left = C; end
        else m_st = 3;
      end else begin
        m_left--;
      end
    end
    m_ls2 = m_ls1; m_ls1 = int'(pll);
    m_bs2 = m_bs1; m_bs1 = int'(btn);
  endfunction

  function automatic logic [4:0] m_exp();
    logic [1:0] s;
    s = m_st[1:0];
    return {s, (m_st <= 1) ? 1'b1 : 1'b0, (m_st != 3) ? 1'b1 : 1'b0, (m_st == 3) ? 1'b1 : 1'b0};
  endfunction

  initial begin
    int pll_left;
    int btn_left;
    logic pv, bv, sv;

    @(negedge clk);
    check("reset_values", outs(), 5'b00_110);
    rst_n = 1'b1;

    add(1,1,0, 2,    2'd0,1,1,0);
    add(1,1,0, 1,    2'd1,1,1,0);
    add(1,1,0, H-1,  2'd1,1,1,0);
    add(1,1,0, 1,    2'd2,0,1,0);
    add(1,1,0, C-1,  2'd2,0,1,0);
    add(1,1,0, 1,    2'd3,0,0,1);
    add(1,1,1, 1,    2'd2,0,1,0);
    add(1,1,0, C-1,  2'd2,0,1,0);
    add(1,1,0, 1,    2'd3,0,0,1);
    add(0,1,0, 1,    2'd3,0,0,1);
    add(1,1,0, 2,    2'd0,1,1,0);
    add(1,1,0, 1,    2'd1,1,1,0);
    add(1,1,0, H,    2'd2,0,1,0);
    add(1,1,0, C,    2'd3,0,0,1);
`ifdef CTRL_RST_DEBOUNCE_EN
    add(1,0,0, 20,   2'd3,0,0,1);
    add(1,1,0, 10,   2'd3,0,0,1);
    add(1,0,0, 40,   2'd1,1,1,0);
    add(1,0,0, 5,    2'd1,1,1,0);
    add(1,1,0, 10,   2'd1,1,1,0);
    add(1,1,0, 20,   2'd3,0,0,1);
`else
    add(1,0,0, 2,    2'd3,0,0,1);
    add(1,0,0, 1,    2'd1,1,1,0);
    add(1,0,0, 20,   2'd1,1,1,0);
    add(1,1,0, H+1,  2'd1,1,1,0);
    add(1,1,0, 1,    2'd2,0,1,0);
    add(1,1,0, C-1,  2'd2,0,1,0);
    add(1,1,0, 1,    2'd3,0,0,1);
`endif
    add(0,1,0, 2,    2'd3,0,0,1);
    add(0,1,1, 1,    2'd0,1,1,0);
    add(1,1,0, 2,    2'd0,1,1,0);
    add(1,1,0, 1,    2'd1,1,1,0);
    add(1,1,0, H,    2'd2,0,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      pll_locked = tbl[i].pll;
      btn_rst_n  = tbl[i].btn;
      sw_rst_req = tbl[i].sw;
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d", i), outs(), {tbl[i].st, tbl[i].sys, tbl[i].cpu, tbl[i].done});
    end

    // Asynchronous reset in the middle of the CPU phase, then full restart
    sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset_mid_cpu", outs(), 5'b00_110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("restart_wait_lock", outs(), 5'b00_110);
    @(posedge clk);
    @(negedge clk);
    check("restart_hold", outs(), 5'b01_110);

    // Randomized run against the reference model
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pll_left = 0;
    btn_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pll_left == 0 && $urandom_range(0, 399) == 0) pll_left = $urandom_range(1, 4);
      pv = (pll_left == 0);
      if (pll_left > 0) pll_left--;
      if (btn_left == 0 && $urandom_range(0, 249) == 0) btn_left = $urandom_range(1, 60);
      bv = (btn_left == 0);
      if (btn_left > 0) btn_left--;
      sv = ($urandom_range(0, 24) == 0);
      pll_locked = pv;
      btn_rst_n  = bv;
      sw_rst_req = sv;
      m_step(pv, bv, sv);
      @(negedge clk);
      check($sformatf("random_cycle%0d", i), outs(), m_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
